sv_switch_debouncer: RTL and testbench

- Upstream input stage for the combinational abcd→xy net. It conditions four raw board switches/buttons into a clean, glitch-free abcd vector.
- Each bit passes through a 2-FF synchronizer, then a per-channel debounce state machine with a hold counter.
- Also emits a one-cycle `changed` strobe whenever the debounced vector changes. Downstream logic can use it to log or latch the resulting xy.

---
 rtl/sv_switch_debouncer_pkg.sv | 15 +
 rtl/sv_debounce_channel.sv | 118 +++++++++++
 rtl/sv_switch_debouncer.sv | 54 +++++
 tb/tb_sv_switch_debouncer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sv_switch_debouncer_pkg.sv
// Shared types and constants for the switch debouncer.
package sv_switch_debouncer_pkg;

    // Per-channel debounce state; the MSB doubles as the debounced level.
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        RISING      = 2'b01,
        STABLE_HIGH = 2'b10,
        FALLING     = 2'b11
    } debounce_state_t;

    // Smallest hold count the channel counter can represent sensibly.
    localparam int MIN_DEBOUNCE_CYCLES = 2;

endpackage

// File: rtl/sv_debounce_channel.sv
// One debounce channel: 2-FF synchronizer, four-state debounce FSM and a
// hold counter. The optional rise/fall strobes exist only when
// SV_SWITCH_DEBOUNCER_EDGE_EN is defined.
module sv_debounce_channel
    import sv_switch_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
`ifdef SV_SWITCH_DEBOUNCER_EDGE_EN
    output logic rise_o,
    output logic fall_o,
`endif
    output logic level_o
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_q1;
    logic             r_q2;
    debounce_state_t  r_state;
    debounce_state_t  w_state_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;

    // Bring the asynchronous switch level into the clock domain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q1 <= 1'b0;
            r_q2 <= 1'b0;
        end else begin
            r_q1 <= raw_i;
            r_q2 <= r_q1;
        end
    end

    // Debounce state and hold counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= STABLE_LOW;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // Next state: any reversal of q2 mid-transition aborts; the counter
    // is left behind by the state exit at CNT_LAST, so it never wraps.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            STABLE_LOW: begin
                if (r_q2) begin
                    w_state_next = RISING;
                    w_count_next = '0;
                end
            end
            RISING: begin
                if (!r_q2) begin
                    w_state_next = STABLE_LOW;
                    w_count_next = '0;
                end else if (r_count == CNT_LAST) begin
                    w_state_next = STABLE_HIGH;
                end else begin
                    w_count_next = r_count + CNT_W'(1);
                end
            end
            STABLE_HIGH: begin
                if (!r_q2) begin
                    w_state_next = FALLING;
                    w_count_next = '0;
                end
            end
            FALLING: begin
                if (r_q2) begin
                    w_state_next = STABLE_HIGH;
                    w_count_next = '0;
                end else if (r_count == CNT_LAST) begin
                    w_state_next = STABLE_LOW;
                end else begin
                    w_count_next = r_count + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = STABLE_LOW;
                w_count_next = '0;
            end
        endcase
    end

    // Debounced level comes from the state register only.
    assign level_o = (r_state == STABLE_HIGH) || (r_state == FALLING);

`ifdef SV_SWITCH_DEBOUNCER_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Registered so the strobes line up with the level change.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= (r_state == RISING)  && (w_state_next == STABLE_HIGH);
            r_fall <= (r_state == FALLING) && (w_state_next == STABLE_LOW);
        end
    end

    assign rise_o = r_rise;
    assign fall_o = r_fall;
`endif

endmodule

// File: rtl/sv_switch_debouncer.sv
// Switch debouncer top: NUM_INPUTS independent channels feeding abcd_o plus
// a one-cycle changed_o strobe. Define SV_SWITCH_DEBOUNCER_EDGE_EN to add the
// per-channel rise_o/fall_o strobes.
module sv_switch_debouncer
    import sv_switch_debouncer_pkg::*;
#(
    parameter int NUM_INPUTS      = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] raw_i,
`ifdef SV_SWITCH_DEBOUNCER_EDGE_EN
    output logic [NUM_INPUTS-1:0] rise_o,
    output logic [NUM_INPUTS-1:0] fall_o,
`endif
    output logic [NUM_INPUTS-1:0] abcd_o,
    output logic                  changed_o
);

    if (DEBOUNCE_CYCLES < MIN_DEBOUNCE_CYCLES) begin : g_bad_cycles
        $error("sv_switch_debouncer: DEBOUNCE_CYCLES must be at least 2");
    end

    logic [NUM_INPUTS-1:0] r_prev;

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_chan
        sv_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clock   (clock),
            .reset   (reset),
            .raw_i   (raw_i[g]),
`ifdef SV_SWITCH_DEBOUNCER_EDGE_EN
            .rise_o  (rise_o[g]),
            .fall_o  (fall_o[g]),
`endif
            .level_o (abcd_o[g])
        );
    end

    // Previous debounced vector; reset together with the channels so that
    // neither reset assertion nor release produces a change strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev <= '0;
        end else begin
            r_prev <= abcd_o;
        end
    end

    assign changed_o = (abcd_o != r_prev);

endmodule

// File: tb/tb_sv_switch_debouncer.sv
// Self-checking bench for sv_switch_debouncer with DEBOUNCE_CYCLES = 4.
// Honors SV_SWITCH_DEBOUNCER_EDGE_EN to also check rise_o/fall_o.
module tb_sv_switch_debouncer;

    localparam int N   = 4;
    localparam int DEB = 4;

    logic         clock;
    logic         reset;
    logic [N-1:0] raw;
    logic [N-1:0] abcd;
    logic         changed;
`ifdef SV_SWITCH_DEBOUNCER_EDGE_EN
    logic [N-1:0] rise;
    logic [N-1:0] fall;
`endif

    int checks   = 0;
    int failures = 0;

    sv_switch_debouncer #(
        .NUM_INPUTS      (N),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .raw_i     (raw),
`ifdef SV_SWITCH_DEBOUNCER_EDGE_EN
        .rise_o    (rise),
        .fall_o    (fall),
`endif
        .abcd_o    (abcd),
        .changed_o (changed)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a channel flips its output once the synchronized
    // level (raw seen two edges earlier) has disagreed with the output on
    // DEB+1 consecutive edges; any agreement resets the run.
    logic [N-1:0] m_h1 = '0;
    logic [N-1:0] m_h2 = '0;
    logic [N-1:0] m_out = '0;
    logic [N-1:0] m_rise = '0;
    logic [N-1:0] m_fall = '0;
    logic         m_changed = 1'b0;
    int           m_run [N];

    task automatic model_step();
        logic [N-1:0] old;
        if (reset) begin
            m_h1 = '0; m_h2 = '0; m_out = '0;
            m_rise = '0; m_fall = '0; m_changed = 1'b0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
        end else begin
            old = m_out;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < N; i++) begin
                if (m_h2[i] != m_out[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB + 1) begin
                        m_out[i] = ~m_out[i];
                        m_run[i] = 0;
                        if (m_out[i]) m_rise[i] = 1'b1;
                        else          m_fall[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_changed = (m_out != old);
            m_h2 = m_h1;
            m_h1 = raw;
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_run[i] = 0;
        forever begin
            @(posedge clock or posedge reset);
            model_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            check("abcd_vs_model", 32'(abcd), 32'(m_out));
            check("changed_vs_model", 32'(changed), 32'(m_changed));
`ifdef SV_SWITCH_DEBOUNCER_EDGE_EN
            check("rise_vs_model", 32'(rise), 32'(m_rise));
            check("fall_vs_model", 32'(fall), 32'(m_fall));
`endif
        end
    end

    initial begin
        logic [11:0] pat;
        reset = 1'b1;
        raw   = '0;
        #1;
        check("reset_abcd", 32'(abcd), 32'h0);
        check("reset_changed", 32'(changed), 32'h0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Idle with all switches low.
        repeat (20) @(posedge clock);
        #1 check("idle_abcd", 32'(abcd), 32'h0);

        // Single switch (b) goes high and is held.
        @(negedge clock);
        raw = 4'b0100;
        repeat (6) @(posedge clock);
        #1 check("b_rise_e5_abcd", 32'(abcd), 32'h0);
        @(posedge clock);
        #1 check("b_rise_e6_abcd", 32'(abcd), 32'h4);
        check("b_rise_e6_changed", 32'(changed), 32'h1);
        @(posedge clock);
        #1 check("b_rise_e7_changed", 32'(changed), 32'h0);
        @(negedge clock);
        raw = 4'b0000;
        repeat (12) @(posedge clock);

        // Three-cycle pulse on a is rejected.
        @(negedge clock);
        raw = 4'b1000;
        repeat (3) @(negedge clock);
        raw = 4'b0000;
        repeat (12) @(posedge clock);
        #1 check("a_pulse_abcd", 32'(abcd), 32'h0);

        // All four high together, then d released.
        @(negedge clock);
        raw = 4'b1111;
        repeat (6) @(posedge clock);
        #1 check("all_rise_e5_abcd", 32'(abcd), 32'h0);
        @(posedge clock);
        #1 check("all_rise_e6_abcd", 32'(abcd), 32'hf);
        check("all_rise_e6_changed", 32'(changed), 32'h1);
        @(negedge clock);
        raw = 4'b1110;
        repeat (6) @(posedge clock);
        #1 check("d_fall_e5_abcd", 32'(abcd), 32'hf);
        @(posedge clock);
        #1 check("d_fall_e6_abcd", 32'(abcd), 32'he);
        check("d_fall_e6_changed", 32'(changed), 32'h1);
`ifdef SV_SWITCH_DEBOUNCER_EDGE_EN
        check("d_fall_e6_fall", 32'(fall), 32'h1);
`endif
        @(negedge clock);
        raw = 4'b0000;
        repeat (12) @(posedge clock);

        // Chatter on c: 1,0,1,1,0 then held high from sample 5.
        pat = 12'b1111_1110_1101;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            raw = {2'b00, pat[i], 1'b0};
        end
        check("chatter_e10_abcd", 32'(abcd), 32'h0);
        @(posedge clock);
        #1 check("chatter_e11_abcd", 32'(abcd), 32'h2);
        @(negedge clock);
        raw = 4'b0000;
        repeat (12) @(posedge clock);

        // Reset in the middle of a rising transition on d.
        @(negedge clock);
        raw = 4'b0001;
        repeat (5) @(posedge clock);
        #1 reset = 1'b1;
        #1 check("midreset_abcd", 32'(abcd), 32'h0);
        check("midreset_changed", 32'(changed), 32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (6) @(posedge clock);
        #1 check("postreset_e5_abcd", 32'(abcd), 32'h0);
        @(posedge clock);
        #1 check("postreset_e6_abcd", 32'(abcd), 32'h1);
        check("postreset_e6_changed", 32'(changed), 32'h1);

        // Randomized switch activity with occasional resets.
        for (int n = 0; n < 4000; n++) begin
            @(negedge clock);
            if ($urandom_range(0, 4) == 0) raw[$urandom_range(0, N-1)] ^= 1'b1;
            if ($urandom_range(0, 399) == 0) begin
                #2 reset = 1'b1;
                @(negedge clock);
                #2 reset = 1'b0;
            end
        end

        repeat (4) @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
